// File: rtl/pong_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_pkg                                                      |
// | Purpose  : Shared constants and types for the Pong VGA renderer:         |
// |            640x480@60 timing, colour constants, rgb_t and a span test.   |
// | Ports    : none (package)                                                |
// | Config   : PONG_CENTER_NET_EN (used by pong_vga_render, C_GREY here)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pong_pkg;

   // Horizontal timing, in pixel clocks.
   localparam int H_VIS  = 640;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;   // 800

   // Vertical timing, in lines.
   localparam int V_VIS  = 480;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;   // 525

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t C_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
   localparam rgb_t C_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
   localparam rgb_t C_RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};
   localparam rgb_t C_BLUE  = '{r: 4'h0, g: 4'h0, b: 4'hF};
   localparam rgb_t C_GREY  = '{r: 4'h8, g: 4'h8, b: 4'h8};

   // lo <= pos < lo+size, evaluated in 11 bits so an object near 1023 does
   // not wrap around and reappear at the left/top edge.
   function automatic logic in_span(input logic [10:0] pos,
                                    input logic [10:0] lo,
                                    input logic [10:0] size);
      return (pos >= lo) && (pos < (lo + size));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pong_vga_timing.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_vga_timing                                               |
// | Purpose  : Pixel/line counters, sync decode, busy and frame_start.       |
// | Ports    : clk, reset        - pixel clock, async active-high reset      |
// |            hcnt_o, vcnt_o    - current scan position                     |
// |            frame_end_o       - high on the last pixel of the frame       |
// |            hs_o, vs_o        - active-low syncs decoded from counters    |
// |                                (combinational, same cycle as counters)   |
// |            busy_o            - registered, high while vcnt < visible     |
// |            frame_start_o     - registered pulse at (0, first blank line) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pong_vga_timing
   import pong_pkg::*;
#(
   parameter int H_VISIBLE = H_VIS,
   parameter int H_FRONT   = H_FP,
   parameter int H_SYNC_W  = H_SYNC,
   parameter int H_TOTAL   = H_TOT,
   parameter int V_VISIBLE = V_VIS,
   parameter int V_FRONT   = V_FP,
   parameter int V_SYNC_W  = V_SYNC,
   parameter int V_TOTAL   = V_TOT
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] hcnt_o,
   output logic [9:0] vcnt_o,
   output logic       frame_end_o,
   output logic       hs_o,
   output logic       vs_o,
   output logic       busy_o,
   output logic       frame_start_o
);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC_W);
   localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC_W);
   localparam logic [9:0] V_VIS10 = 10'(V_VISIBLE);

   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       busy_q;
   logic       frame_start_q;

   always_comb begin
      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end
   end

   // busy and frame_start are computed from the next counter values so that,
   // once registered, they line up with the counters they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         busy_q        <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         busy_q        <= (vcnt_d < V_VIS10);
         frame_start_q <= (hcnt_d == 10'd0) && (vcnt_d == V_VIS10);
      end
   end

   assign hcnt_o        = hcnt_q;
   assign vcnt_o        = vcnt_q;
   assign frame_end_o   = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
   assign hs_o          = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
   assign vs_o          = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
   assign busy_o        = busy_q;
   assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: rtl/pong_vga_render.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_vga_render                                               |
// | Purpose  : Renders a ball and two paddles onto a 640x480 VGA raster.     |
// |            Object positions are captured once per frame into shadow      |
// |            registers so CPU updates never tear the picture.              |
// | Ports    : clk, reset              - pixel clock, async active-high rst  |
// |            bx, by                  - ball top-left position             |
// |            p1x, p1y, p2x, p2y      - paddle top-left positions           |
// |            busy, frame_start       - CPU handshake                       |
// |            vga_hs, vga_vs          - active-low syncs                    |
// |            vga_blank_n             - high in the visible area            |
// |            vga_r, vga_g, vga_b     - 4-bit colour                        |
// | Config   : `define PONG_CENTER_NET_EN draws a dashed grey centre net.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pong_vga_render
   import pong_pkg::*;
#(
   parameter int BALL_SIZE = 8,
   parameter int PAD_W     = 8,
   parameter int PAD_H     = 48,
   parameter int H_VISIBLE = H_VIS,
   parameter int H_FRONT   = H_FP,
   parameter int H_SYNC_W  = H_SYNC,
   parameter int H_TOTAL   = H_TOT,
   parameter int V_VISIBLE = V_VIS,
   parameter int V_FRONT   = V_FP,
   parameter int V_SYNC_W  = V_SYNC,
   parameter int V_TOTAL   = V_TOT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] bx,
   input  logic [9:0] by,
   input  logic [9:0] p1x,
   input  logic [9:0] p1y,
   input  logic [9:0] p2x,
   input  logic [9:0] p2y,
   output logic       busy,
   output logic       frame_start,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b
);

   localparam logic [9:0]  H_VIS10 = 10'(H_VISIBLE);
   localparam logic [9:0]  V_VIS10 = 10'(V_VISIBLE);
   localparam logic [10:0] BALL_SZ = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_WSZ = 11'(PAD_W);
   localparam logic [10:0] PAD_HSZ = 11'(PAD_H);

   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       frame_end;
   logic       hs_w;
   logic       vs_w;

   pong_vga_timing #(
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC_W  (H_SYNC_W),
      .H_TOTAL   (H_TOTAL),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC_W  (V_SYNC_W),
      .V_TOTAL   (V_TOTAL)
   ) u_timing (
      .clk           (clk),
      .reset         (reset),
      .hcnt_o        (hcnt),
      .vcnt_o        (vcnt),
      .frame_end_o   (frame_end),
      .hs_o          (hs_w),
      .vs_o          (vs_w),
      .busy_o        (busy),
      .frame_start_o (frame_start)
   );

   // ------------------------------------------------------------------
   // Shadow registers: sampled on the very last pixel of the frame so the
   // whole following frame is drawn from one consistent snapshot.
   // ------------------------------------------------------------------
   logic [9:0] bx_q, by_q, p1x_q, p1y_q, p2x_q, p2y_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bx_q  <= '0;
         by_q  <= '0;
         p1x_q <= '0;
         p1y_q <= '0;
         p2x_q <= '0;
         p2y_q <= '0;
      end else if (frame_end) begin
         bx_q  <= bx;
         by_q  <= by;
         p1x_q <= p1x;
         p1y_q <= p1y;
         p2x_q <= p2x;
         p2y_q <= p2y;
      end
   end

   // ------------------------------------------------------------------
   // Hit tests on the current scan position.
   // ------------------------------------------------------------------
   logic [10:0] x;
   logic [10:0] y;
   logic        visible;
   logic        hit_ball;
   logic        hit_p1;
   logic        hit_p2;

   assign x        = {1'b0, hcnt};
   assign y        = {1'b0, vcnt};
   assign visible  = (hcnt < H_VIS10) && (vcnt < V_VIS10);
   assign hit_ball = in_span(x, {1'b0, bx_q},  BALL_SZ) && in_span(y, {1'b0, by_q},  BALL_SZ);
   assign hit_p1   = in_span(x, {1'b0, p1x_q}, PAD_WSZ) && in_span(y, {1'b0, p1y_q}, PAD_HSZ);
   assign hit_p2   = in_span(x, {1'b0, p2x_q}, PAD_WSZ) && in_span(y, {1'b0, p2y_q}, PAD_HSZ);

`ifdef PONG_CENTER_NET_EN
   // Four columns straddling the screen centre, dashed 8 lines on / 8 off.
   localparam logic [10:0] NET_LO = 11'(H_VISIBLE / 2 - 2);
   localparam logic [10:0] NET_HI = 11'(H_VISIBLE / 2 + 1);
   logic hit_net;
   assign hit_net = (x >= NET_LO) && (x <= NET_HI) && !y[3];
`endif

   // ------------------------------------------------------------------
   // Colour mux. Clipping is implicit: anything outside the visible
   // window is forced black regardless of object overlap.
   // ------------------------------------------------------------------
   rgb_t pix_d;
   rgb_t pix_q;
   logic blank_n_q;
   logic hs_q;
   logic vs_q;

   always_comb begin
      pix_d = C_BLACK;
      if (visible) begin
         if (hit_ball)
            pix_d = C_WHITE;
         else if (hit_p1)
            pix_d = C_RED;
         else if (hit_p2)
            pix_d = C_BLUE;
`ifdef PONG_CENTER_NET_EN
         else if (hit_net)
            pix_d = C_GREY;
`endif
      end
   end

   // Syncs go through the same register stage as the colour so all four
   // video outputs stay mutually aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_q     <= C_BLACK;
         blank_n_q <= 1'b0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
      end else begin
         pix_q     <= pix_d;
         blank_n_q <= visible;
         hs_q      <= hs_w;
         vs_q      <= vs_w;
      end
   end

   assign vga_r       = pix_q.r;
   assign vga_g       = pix_q.g;
   assign vga_b       = pix_q.b;
   assign vga_blank_n = blank_n_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_vga_render.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pong_vga_render                                            |
// | Purpose  : Scoreboard bench for pong_vga_render on a reduced raster      |
// |            (64x38 total, 48x32 visible) so many frames fit in the run.   |
// |            Honours PONG_CENTER_NET_EN in its reference model.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pong_vga_render;

   localparam int HV = 48, HF = 4, HS = 8, HT = 64;
   localparam int VV = 32, VF = 2, VS = 2, VT = 38;
   localparam int BS = 8, PW = 8, PH = 12;
   localparam int LIM = 3 * HT * VT;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] bx, by, p1x, p1y, p2x, p2y;
   logic       busy, frame_start, vga_hs, vga_vs, vga_blank_n;
   logic [3:0] vga_r, vga_g, vga_b;

   pong_vga_render #(
      .BALL_SIZE (BS), .PAD_W (PW), .PAD_H (PH),
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC_W (HS), .H_TOTAL (HT),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC_W (VS), .V_TOTAL (VT)
   ) dut (
      .clk (clk), .reset (reset),
      .bx (bx), .by (by), .p1x (p1x), .p1y (p1y), .p2x (p2x), .p2y (p2y),
      .busy (busy), .frame_start (frame_start),
      .vga_hs (vga_hs), .vga_vs (vga_vs), .vga_blank_n (vga_blank_n),
      .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int fs_cnt = 0;

   typedef struct {
      int         h;
      int         v;
      logic [11:0] rgb;
      logic       blank_n;
      logic       hs;
      logic       vs;
      logic       busy;
      logic       fs;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   exp_t        mdl_e;
   int          mh, mv;                              // model scan position
   int          sbx, sby, s1x, s1y, s2x, s2y;        // model snapshot
   logic [12:0] fb [0:VT-1][0:HT-1];                 // {blank_n, rgb} seen

   function automatic logic inbox(int x, int y, int ox, int oy, int w, int h);
      return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + h);
   endfunction

   function automatic logic [11:0] ref_rgb(int x, int y);
      if (x >= HV || y >= VV)             return 12'h000;
      if (inbox(x, y, sbx, sby, BS, BS))  return 12'hFFF;
      if (inbox(x, y, s1x, s1y, PW, PH))  return 12'hF00;
      if (inbox(x, y, s2x, s2y, PW, PH))  return 12'h00F;
`ifdef PONG_CENTER_NET_EN
      if (x >= HV/2 - 2 && x <= HV/2 + 1 && (y % 16) < 8) return 12'h888;
`endif
      return 12'h000;
   endfunction

   // Reference model: on each active edge, the pixel of the position just
   // left is what the DUT shows next; busy/frame_start follow the new one.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         mh = 0; mv = 0;
         sbx = 0; sby = 0; s1x = 0; s1y = 0; s2x = 0; s2y = 0;
      end else begin
         mdl_e.h       = mh;
         mdl_e.v       = mv;
         mdl_e.rgb     = ref_rgb(mh, mv);
         mdl_e.blank_n = (mh < HV) && (mv < VV);
         mdl_e.hs      = !(mh >= HV + HF && mh < HV + HF + HS);
         mdl_e.vs      = !(mv >= VV + VF && mv < VV + VF + VS);
         if (mh == HT - 1 && mv == VT - 1) begin
            sbx = int'(bx); sby = int'(by); s1x = int'(p1x);
            s1y = int'(p1y); s2x = int'(p2x); s2y = int'(p2y);
         end
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end
         mdl_e.busy = (mv < VV);
         mdl_e.fs   = (mh == 0) && (mv == VV);
         exp_q.push_back(mdl_e);
      end
   end

   // Monitor: one comparison per presented pixel.
   always @(negedge clk) begin
      if (!reset && exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         tests = tests + 1;
         if ({vga_r, vga_g, vga_b, vga_blank_n, vga_hs, vga_vs, busy, frame_start} !==
             {mon_e.rgb, mon_e.blank_n, mon_e.hs, mon_e.vs, mon_e.busy, mon_e.fs}) begin
            fails = fails + 1;
            $display("FAIL pixel(%0d,%0d): got rgb=%03h blank_n=%b hs=%b vs=%b busy=%b fs=%b, expected rgb=%03h blank_n=%b hs=%b vs=%b busy=%b fs=%b",
                     mon_e.h, mon_e.v, {vga_r, vga_g, vga_b}, vga_blank_n, vga_hs, vga_vs, busy, frame_start,
                     mon_e.rgb, mon_e.blank_n, mon_e.hs, mon_e.vs, mon_e.busy, mon_e.fs);
         end
         fb[mon_e.v][mon_e.h] = {vga_blank_n, vga_r, vga_g, vga_b};
      end
      if (!reset && frame_start) fs_cnt = fs_cnt + 1;
   end

   task automatic check(input string name, input int act, input int expv);
      tests = tests + 1;
      if (act !== expv) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic timeout(input string name);
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL %s: timed out after %0d cycles, expected event", name, LIM);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  int'(busy),        0);
      check({tag, "_fs"},    int'(frame_start), 0);
      check({tag, "_hs"},    int'(vga_hs),      1);
      check({tag, "_vs"},    int'(vga_vs),      1);
      check({tag, "_blank"}, int'(vga_blank_n), 0);
      check({tag, "_rgb"},   int'({vga_r, vga_g, vga_b}), 0);
   endtask

   // Returns one cycle into the next frame; by then the previous frame has
   // been fully captured into fb.
   task automatic next_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(mh == 0 && mv == 0) && n < LIM);
      if (n >= LIM) timeout("next_frame");
      @(negedge clk);
   endtask

   task automatic wait_row(input int row);
      int n = 0;
      while (!(mh == 0 && mv == row) && n < LIM) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIM) timeout("wait_row");
   endtask

   task automatic show_frame();
      next_frame();   // snapshot taken, new frame begins
      next_frame();   // that frame is now in fb
   endtask

   function automatic logic sync_sig(input int s);
      return (s == 0) ? vga_hs : vga_vs;
   endfunction

   task automatic measure(input int s, input int exp_low, input int exp_per);
      int n = 0, low = 0, high = 0, fs0;
      while (sync_sig(s) !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      while (sync_sig(s) !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
      fs0 = fs_cnt;
      while (sync_sig(s) === 1'b0 && n < LIM) begin @(negedge clk); n++; low++; end
      while (sync_sig(s) === 1'b1 && n < LIM) begin @(negedge clk); n++; high++; end
      if (n >= LIM) timeout(s == 0 ? "hs_measure" : "vs_measure");
      else begin
         check(s == 0 ? "hs_low"    : "vs_low",    low,        exp_low);
         check(s == 0 ? "hs_period" : "vs_period", low + high, exp_per);
         if (s == 1) check("frame_start_per_frame", fs_cnt - fs0, 1);
      end
   endtask

   task automatic px(input string name, input int x, input int y, input logic [12:0] expv);
      check(name, int'(fb[y][x]), int'(expv));
   endtask

   localparam logic [12:0] WHITE = 13'h1FFF, RED = 13'h1F00, BLUE = 13'h100F;
   localparam logic [12:0] BLACK = 13'h1000, BLANK = 13'h0000, GREY = 13'h1888;

   initial begin
      bx = 10'd10; by = 10'd20; p1x = 10'd2; p1y = 10'd2; p2x = 10'd38; p2y = 10'd10;

      repeat (4) begin
         @(negedge clk);
         check_reset_outputs("reset_hold");
      end
      reset = 1'b0;

      measure(0, HS, HT);
      measure(1, HT * VS, HT * VT);

      // Basic ball, paddles, net.
      show_frame();
      px("ball_tl",      10, 20, WHITE);
      px("ball_br",      17, 27, WHITE);
      px("ball_right",   18, 20, BLACK);
      px("ball_below",   10, 28, BLACK);
      px("ball_left",     9, 20, BLACK);
      px("paddle1",       3,  3, RED);
      px("paddle2",      40, 15, BLUE);
`ifdef PONG_CENTER_NET_EN
      px("net_on",    HV/2,  0, GREY);
`else
      px("net_on",    HV/2,  0, BLACK);
`endif
      px("net_gap",   HV/2,  8, BLACK);

      // Mid-frame move is deferred to the next frame.
      wait_row(VV / 2);
      bx = 10'd30;
      next_frame();
      px("mid_old_pos",  10, 20, WHITE);
      px("mid_new_pos",  30, 20, BLACK);
      next_frame();
      px("next_new_pos", 30, 20, WHITE);
      px("next_old_pos", 10, 20, BLACK);

      // Ball over paddle 1.
      bx = 10'd5; by = 10'd6; p1x = 10'd5; p1y = 10'd6;
      show_frame();
      px("ovl_tl",        5,  6, WHITE);
      px("ovl_br",       12, 13, WHITE);
      px("pad_only_a",    5, 14, RED);
      px("pad_only_b",   12, 17, RED);
      px("pad_end",       5, 18, BLACK);

      // Right-edge clipping.
      bx = 10'(HV - 4); by = 10'd20; p1x = 10'd2; p1y = 10'd2;
      show_frame();
      px("clip_first", HV - 4, 20, WHITE);
      px("clip_last",  HV - 1, 20, WHITE);
      px("clip_blank0",    HV, 20, BLANK);
      px("clip_blank2", HV + 2, 20, BLANK);
      for (int i = 0; i < 4; i++) px("clip_nowrap", i, 20, BLACK);

      // Ball parked near 1023: must not wrap onto the left edge.
      bx = 10'd1020;
      show_frame();
      for (int i = 0; i < 4; i++) px("far_nowrap", i, 20, BLACK);
      px("far_right",  HV - 1, 20, BLACK);

      // Reset in the middle of the visible area.
      wait_row(10);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_outputs("midframe_reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Random positions, including mid-frame updates.
      repeat (4) begin
         bx  = 10'($urandom_range(0, 63));  by  = 10'($urandom_range(0, 40));
         p1x = 10'($urandom_range(0, 63));  p1y = 10'($urandom_range(0, 40));
         p2x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
         p2y = 10'($urandom_range(0, 40));
         wait_row($urandom_range(1, VT - 2));
         bx  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023)) : 10'($urandom_range(0, 63));
         p1y = 10'($urandom_range(0, 40));
         next_frame();
      end
      next_frame();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pong_vga_render.md
PONG_VGA_RENDER -- requirements
Module: pong_vga_render

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- BALL_SIZE, 8, ball square side in pixels.
- PAD_W, 8, paddle width in pixels.
- PAD_H, 48, paddle height in pixels.
REQ-002 clk  in  1  25 MHz pixel clock; single clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 bx, by  in  10 each  ball top-left x/y from the CPU PIO ports.
REQ-005 p1x, p1y, p2x, p2y  in  10 each  paddle top-left x/y from the CPU PIO ports.
REQ-006 busy  out  1  high while the scan is inside visible rows; drives the CPU busy input.
REQ-007 frame_start  out  1  one-cycle pulse at the start of vertical blanking; drives the CPU start input.
REQ-008 vga_hs, vga_vs  out  1 each  horizontal and vertical sync, both active low.
REQ-009 vga_blank_n  out  1  high during the visible area.
REQ-010 vga_r, vga_g, vga_b  out  4 each  pixel colour.

Function
REQ-011 The hcnt counter shall count 0..799 and wrap to 0. The vcnt counter shall advance when hcnt=799 and wrap after 524.
REQ-012 Visible area: hcnt<640 and vcnt<480.
REQ-013 Hsync shall be low for hcnt 656..751; vsync shall be low for vcnt 490..491.
REQ-014 Shadow registers shall latch all six positions in the cycle where hcnt=799 and vcnt=524; the shadow values shall remain constant for the whole next frame.
REQ-015 busy shall be 1 when vcnt<480, registered and aligned with the counters.
REQ-016 frame_start shall be 1 for exactly one cycle when hcnt=0 and vcnt=480.
REQ-017 Hit tests shall be computed in 11 bits, with no wrap at 1023:
- ball: bx<=x<bx+BALL_SIZE and by<=y<by+BALL_SIZE.
- paddles: the same rule using PAD_W and PAD_H.
REQ-018 Colour priority: ball (F,F,F) > paddle1 (F,0,0) > paddle2 (0,0,F) > centre net (when enabled) > background (0,0,0).
REQ-019 Outside the visible area, RGB shall be 0 and vga_blank_n shall be 0.
REQ-020 Latency: RGB, blank_n, hs and vs shall be registered one cycle after the counters, and all four shall be mutually aligned.
REQ-021 Objects partly beyond x=639 or y=479 shall be clipped; no artefact shall appear in blanking.
REQ-022 A position change in mid-frame shall have no visible effect until the next latch.

Reset
REQ-023 While reset is high, all of the following shall be held:
- hcnt=0 and vcnt=0.
- shadow registers = 0.
- busy=0 and frame_start=0.
- vga_hs=1 and vga_vs=1.
- vga_blank_n=0 and RGB=0.
REQ-024 After reset is released, scanning shall restart at hcnt=0, vcnt=0. A reset asserted mid-frame shall abort the frame immediately.

Configuration
REQ-025 Macro PONG_CENTER_NET_EN:
- When defined, pixels with x in 318..321 and y[3]=0 shall draw grey (8,8,8) at the net priority.
- When undefined, the net logic shall be absent and those pixels shall show the background.

Structure
REQ-026 A shared package pong_pkg shall hold:
- the timing constants (H_VIS, H_FP, H_SYNC, H_TOT, V_VIS, V_FP, V_SYNC, V_TOT);
- the colour constants;
- the rgb_t typedef.
REQ-027 A sub-module pong_vga_timing shall hold the counters, the sync decode, and the generation of busy and frame_start. The top level shall hold the shadow registers, the hit tests and the colour mux.

Verification
REQ-028 Reset, then run 2 frames: hs period = 800 cycles, low for 96 cycles; vs period = 420000 cycles, low for 1600 cycles; frame_start occurs once per frame.
REQ-029 Set bx=100, by=200: the ball renders white at x 100..107 and y 200..207; pixel (108,200) is background.
REQ-030 Change bx from 100 to 300 while vcnt=240: the current frame still shows the ball at x=100; the next frame shows it at x=300.
REQ-031 Overlap with p1x=bx=50 and p1y=by=60: overlapping pixels render white; paddle-only pixels render red.
REQ-032 Set bx=636, then bx=1020: the ball is clipped at x=639 in both cases, with no wrap to x=0..3 and RGB=0 in blanking.
REQ-033 Build with and without PONG_CENTER_NET_EN: pixel (320,0) is grey with the macro and black without it; pixel (320,8) is black in both builds.
